dm_axi_master: RTL and testbench
================================

Name: dm_axi_master

Overview:
- CPU-side data-memory master. It takes the MEM-stage load/store request (read enable, active-low byte write enables, address, store data) and turns it into a single-beat AXI4 read or write transaction.
- While the transaction is in flight it drives DM_STALL, which freezes the pipeline registers.
- It returns load data to the MEM/WB path in the same cycle the pipeline is released.

Parameters:
- ID_WIDTH, 4, width of the AXI ID fields.
- MASTER_ID, 4'd1, constant value driven on ARID/AWID.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_read  in  1  load request (MEM_MemRead).
- req_web  in  4  active-low byte write enables; 4'hf means no store.
- req_addr  in  32  byte address (MEM_ALU_out).
- req_wdata  in  32  store data, already lane-aligned.
- DM_STALL  out  1  pipeline hold while a transaction is pending.
- rdata  out  32  load data.
- resp_err  out  1  one-cycle pulse on a non-OKAY RRESP/BRESP.
- ARID/ARADDR/ARLEN[3:0]/ARSIZE[2:0]/ARBURST[1:0]/ARVALID  out; ARREADY  in.
- RID/RDATA[31:0]/RRESP[1:0]/RLAST/RVALID  in; RREADY  out.
- AWID/AWADDR/AWLEN[3:0]/AWSIZE[2:0]/AWBURST[1:0]/AWVALID  out; AWREADY  in.
- WDATA[31:0]/WSTRB[3:0]/WLAST/WVALID  out; WREADY  in.
- BID/BRESP[1:0]/BVALID  in; BREADY  out.

Behaviour:
- One clock (clk). Reset rst is synchronous and active-high; all state updates on the rising edge of clk.
- Constant outputs: ARLEN = AWLEN = 0, ARSIZE = AWSIZE = 3'b010, ARBURST = AWBURST = 2'b01, WLAST = 1, ARID = AWID = MASTER_ID.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP.
- IDLE:
  - store = (req_web != 4'hf); load = req_read & ~store.
  - A store has priority over a simultaneous req_read.
  - On store or load: capture req_addr into addr_q, req_wdata into wdata_q and ~req_web into strb_q, then go to WR_ADDR_DATA or RD_ADDR.
- RD_ADDR:
  - ARVALID = 1, ARADDR = addr_q.
  - On ARVALID & ARREADY, go to RD_DATA.
- RD_DATA:
  - RREADY = 1.
  - On RVALID: go to IDLE, load rdata_q <= RDATA, pulse resp_err if RRESP != 0.
- WR_ADDR_DATA:
  - AWVALID = ~aw_done and WVALID = ~w_done, with AWADDR = addr_q, WDATA = wdata_q, WSTRB = strb_q.
  - Each channel sets its done flag on its own handshake; the channels may complete in either order or in the same cycle.
  - When both are complete (flag set or handshaking this cycle), go to WR_RESP and clear both flags.
- WR_RESP:
  - BREADY = 1.
  - On BVALID, go to IDLE; pulse resp_err if BRESP != 0.
- All VALID/READY outputs are decoded from registered state and flags only. AR/AW/W payloads stay stable while VALID is high, and VALID never drops before its handshake.
- DM_STALL (combinational):
  - 1 in IDLE when store or load is present.
  - 1 in RD_ADDR and WR_ADDR_DATA.
  - 1 in RD_DATA while ~RVALID, and in WR_RESP while ~BVALID.
  - 0 otherwise, so it falls in the completion cycle and the pipeline advances on that edge.
- rdata = RVALID ? RDATA : rdata_q while in RD_DATA; rdata_q in all other states.
- Minimum latency with an always-ready slave: DM_STALL is high for 2 cycles and low in the 3rd, which is the completion cycle.
- Request deassertion: the request is sampled only in IDLE. A change on the req_* inputs while busy is ignored.
- No reissue: after completion the FSM is in IDLE. The pipeline register has either advanced or cleared its MemRead/MemWrite, so no second transaction is issued for the same instruction.
- Reset values: state IDLE, flags 0, addr_q/wdata_q/rdata_q 0, strb_q 0. All VALIDs, RREADY, BREADY, resp_err and DM_STALL are 0.
- Reset mid-transaction: return to IDLE on the next edge with all VALID/READY at 0. The outstanding beat is abandoned; the interconnect is reset on the same rst.
- RID/BID/RLAST are not checked.

Test Plan:
- Reset: hold rst for 2 cycles with req_read=1 -> all VALIDs 0, DM_STALL 0, rdata 0. After release, ARVALID rises 1 cycle later.
- Load, ready slave: req_read=1, addr 0x0001_0008, ARREADY=1, RVALID=1 with RDATA 0xDEADBEEF on the next cycle -> ARADDR 0x0001_0008. DM_STALL high for 2 cycles, low in the RVALID cycle, with rdata = 0xDEADBEEF in that cycle and held afterwards.
- Store, AW before W: req_web=4'b1100, wdata 0x1234_5678, AWREADY=1 in cycle 1, WREADY delayed 3 cycles -> AWVALID drops after cycle 1. WVALID is held with WSTRB=4'b0011 until WREADY, then BREADY=1. DM_STALL falls in the BVALID cycle.
- Store, W before AW, and both in the same cycle -> exactly one AW and one W handshake each; transition to WR_RESP in the cycle the second handshake completes.
- Store with req_read=1 simultaneously -> only the AW/W channels are used; ARVALID is never asserted.
- Slave stalls and errors: ARREADY low 5 cycles, RRESP=2'b10 -> ARADDR stable throughout, resp_err pulses for 1 cycle. A rst asserted during RD_DATA -> IDLE on the next edge with RREADY=0.

Source files
------------

// File: rtl/dm_axi_if.sv
// Single-beat AXI4 bus between the data-memory master and its slave/interconnect.
interface dm_axi_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] ARID;
    logic [31:0]         ARADDR;
    logic [3:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_WIDTH-1:0] RID;
    logic [31:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [ID_WIDTH-1:0] AWID;
    logic [31:0]         AWADDR;
    logic [3:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [31:0]         WDATA;
    logic [3:0]          WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_WIDTH-1:0] BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
        output WDATA, WSTRB, WLAST, WVALID, input WREADY,
        input  BID, BRESP, BVALID, output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID, input RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
        output BID, BRESP, BVALID, input BREADY
    );
endinterface

// File: rtl/dm_axi_master.sv
// MEM-stage load/store to single-beat AXI4 transaction; holds the pipeline via
// DM_STALL until the read data or write response arrives.
module dm_axi_master #(
    parameter int                  ID_WIDTH  = 4,
    parameter logic [ID_WIDTH-1:0] MASTER_ID = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic [3:0]  req_web,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        DM_STALL,
    output logic [31:0] rdata,
    output logic        resp_err,
    dm_axi_if.master    axi
);
    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP} state_t;

    state_t      state;
    logic        aw_done, w_done;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  strb_q;

    logic store, load, aw_hs, w_hs;
    assign store = (req_web != 4'hf);
    assign load  = req_read & ~store;
    assign aw_hs = axi.AWVALID & axi.AWREADY;
    assign w_hs  = axi.WVALID & axi.WREADY;

    assign axi.ARID    = MASTER_ID;
    assign axi.AWID    = MASTER_ID;
    assign axi.ARLEN   = 4'd0;
    assign axi.AWLEN   = 4'd0;
    assign axi.ARSIZE  = 3'b010;
    assign axi.AWSIZE  = 3'b010;
    assign axi.ARBURST = 2'b01;
    assign axi.AWBURST = 2'b01;
    assign axi.WLAST   = 1'b1;

    // Handshake controls come only from registered state so they cannot glitch
    // with slave inputs; payloads are the captured request.
    assign axi.ARVALID = (state == RD_ADDR);
    assign axi.ARADDR  = addr_q;
    assign axi.RREADY  = (state == RD_DATA);
    assign axi.AWVALID = (state == WR_ADDR_DATA) & ~aw_done;
    assign axi.AWADDR  = addr_q;
    assign axi.WVALID  = (state == WR_ADDR_DATA) & ~w_done;
    assign axi.WDATA   = wdata_q;
    assign axi.WSTRB   = strb_q;
    assign axi.BREADY  = (state == WR_RESP);

    always_comb begin
        DM_STALL = 1'b0;
        case (state)
            IDLE:         DM_STALL = store | load;
            RD_ADDR:      DM_STALL = 1'b1;
            RD_DATA:      DM_STALL = ~axi.RVALID;
            WR_ADDR_DATA: DM_STALL = 1'b1;
            WR_RESP:      DM_STALL = ~axi.BVALID;
            default:      DM_STALL = 1'b0;
        endcase
        if (rst) DM_STALL = 1'b0;
    end

    // Forward RDATA in the completion cycle so MEM/WB sees it as the stall drops.
    assign rdata = (state == RD_DATA && axi.RVALID) ? axi.RDATA : rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            strb_q   <= '0;
            resp_err <= 1'b0;
        end else begin
            resp_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (store || load) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        strb_q  <= ~req_web;
                        state   <= store ? WR_ADDR_DATA : RD_ADDR;
                    end
                end
                RD_ADDR: if (axi.ARREADY) state <= RD_DATA;
                RD_DATA: begin
                    if (axi.RVALID) begin
                        rdata_q  <= axi.RDATA;
                        resp_err <= (axi.RRESP != 2'b00);
                        state    <= IDLE;
                    end
                end
                WR_ADDR_DATA: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= WR_RESP;
                    end else begin
                        aw_done <= aw_done | aw_hs;
                        w_done  <= w_done | w_hs;
                    end
                end
                WR_RESP: begin
                    if (axi.BVALID) begin
                        resp_err <= (axi.BRESP != 2'b00);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = ^{axi.RID, axi.BID, axi.RLAST};
endmodule

// File: tb/tb_dm_axi_master.sv
// Directed bench for dm_axi_master: the bench plays the AXI slave cycle by cycle.
module tb_dm_axi_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_read;
    logic [3:0]  req_web;
    logic [31:0] req_addr, req_wdata;
    logic        DM_STALL, resp_err;
    logic [31:0] rdata;

    int n_tests = 0;
    int n_fail  = 0;
    int aw_cnt = 0, w_cnt = 0, ar_hi = 0;
    int aw0, w0, ar0;

    dm_axi_if #(.ID_WIDTH(4)) axi ();

    dm_axi_master #(.ID_WIDTH(4), .MASTER_ID(4'd1)) dut (
        .clk(clk), .rst(rst), .req_read(req_read), .req_web(req_web),
        .req_addr(req_addr), .req_wdata(req_wdata), .DM_STALL(DM_STALL),
        .rdata(rdata), .resp_err(resp_err), .axi(axi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (axi.AWVALID && axi.AWREADY) aw_cnt <= aw_cnt + 1;
        if (axi.WVALID && axi.WREADY)   w_cnt  <= w_cnt + 1;
        if (axi.ARVALID)                ar_hi  <= ar_hi + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; checks happen 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; req_read = 1'b1; req_web = 4'hf; req_addr = '0; req_wdata = '0;
        axi.ARREADY = 0; axi.RVALID = 0; axi.RDATA = '0; axi.RRESP = 0; axi.RID = 4'd1;
        axi.RLAST = 1; axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 0; axi.BRESP = 0;
        axi.BID = 4'd1;

        // Reset held two cycles with a pending load
        cyc(); cyc(); #1;
        chk("rst_arvalid", axi.ARVALID, 0);
        chk("rst_awvalid", axi.AWVALID, 0);
        chk("rst_wvalid", axi.WVALID, 0);
        chk("rst_rready", axi.RREADY, 0);
        chk("rst_bready", axi.BREADY, 0);
        chk("rst_stall", DM_STALL, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_err", resp_err, 0);
        rst = 1'b0;
        cyc(); #1;
        chk("post_rst_arvalid", axi.ARVALID, 1);
        chk("arid", axi.ARID, 4'd1);
        chk("arsize", {axi.ARLEN, axi.ARSIZE, axi.ARBURST}, {4'd0, 3'b010, 2'b01});
        axi.ARREADY = 1;
        cyc(); axi.ARREADY = 0; axi.RVALID = 1; axi.RDATA = 32'h1111_2222; req_read = 0;
        cyc(); axi.RVALID = 0;

        // Load with an always-ready slave
        cyc(); req_read = 1; req_addr = 32'h0001_0008; axi.ARREADY = 1; #1;
        chk("ld_stall_c0", DM_STALL, 1);
        cyc(); #1;
        chk("ld_arvalid", axi.ARVALID, 1);
        chk("ld_araddr", axi.ARADDR, 32'h0001_0008);
        chk("ld_stall_c1", DM_STALL, 1);
        cyc(); axi.ARREADY = 0; axi.RVALID = 1; axi.RDATA = 32'hDEAD_BEEF; req_read = 0; #1;
        chk("ld_rready", axi.RREADY, 1);
        chk("ld_stall_c2", DM_STALL, 0);
        chk("ld_rdata_fwd", rdata, 32'hDEAD_BEEF);
        cyc(); axi.RVALID = 0; axi.RDATA = '0; #1;
        chk("ld_rdata_held", rdata, 32'hDEAD_BEEF);
        chk("ld_idle_stall", DM_STALL, 0);
        chk("ld_idle_rready", axi.RREADY, 0);
        chk("ld_no_err", resp_err, 0);

        // Store, AW accepted first, W delayed
        aw0 = aw_cnt; w0 = w_cnt;
        req_web = 4'b1100; req_wdata = 32'h1234_5678; req_addr = 32'h0000_0200;
        axi.AWREADY = 1; #1;
        chk("st1_stall_c0", DM_STALL, 1);
        cyc(); req_web = 4'hf; #1;
        chk("st1_awvalid_c1", axi.AWVALID, 1);
        chk("st1_awaddr", axi.AWADDR, 32'h0000_0200);
        chk("st1_wvalid_c1", axi.WVALID, 1);
        chk("st1_wstrb", axi.WSTRB, 4'b0011);
        chk("st1_awid", axi.AWID, 4'd1);
        chk("st1_wlast", axi.WLAST, 1);
        cyc(); axi.AWREADY = 0; #1;
        chk("st1_awvalid_drop", axi.AWVALID, 0);
        chk("st1_wvalid_c2", axi.WVALID, 1);
        chk("st1_wdata", axi.WDATA, 32'h1234_5678);
        chk("st1_stall_c2", DM_STALL, 1);
        cyc(); #1;
        chk("st1_wvalid_c3", axi.WVALID, 1);
        cyc(); axi.WREADY = 1; #1;
        chk("st1_wvalid_c4", axi.WVALID, 1);
        chk("st1_wstrb_c4", axi.WSTRB, 4'b0011);
        cyc(); axi.WREADY = 0; #1;
        chk("st1_bready", axi.BREADY, 1);
        chk("st1_wvalid_done", axi.WVALID, 0);
        chk("st1_stall_wait_b", DM_STALL, 1);
        cyc(); axi.BVALID = 1; #1;
        chk("st1_stall_bvalid", DM_STALL, 0);
        cyc(); axi.BVALID = 0; #1;
        chk("st1_bready_idle", axi.BREADY, 0);
        chk("st1_err", resp_err, 0);
        chk("st1_aw_cnt", aw_cnt - aw0, 1);
        chk("st1_w_cnt", w_cnt - w0, 1);

        // Store, W accepted before AW
        aw0 = aw_cnt; w0 = w_cnt;
        req_web = 4'b0000; req_wdata = 32'hA5A5_5A5A; req_addr = 32'h0000_0300;
        axi.WREADY = 1;
        cyc(); req_web = 4'hf; #1;
        chk("st2_both_valid", {axi.AWVALID, axi.WVALID}, 2'b11);
        cyc(); axi.WREADY = 0; #1;
        chk("st2_w_dropped", {axi.AWVALID, axi.WVALID}, 2'b10);
        cyc(); axi.AWREADY = 1; #1;
        chk("st2_still_addr", axi.BREADY, 0);
        cyc(); axi.AWREADY = 0; #1;
        chk("st2_bready", axi.BREADY, 1);
        chk("st2_valids_low", {axi.AWVALID, axi.WVALID}, 2'b00);
        axi.BVALID = 1;
        cyc(); axi.BVALID = 0; #1;
        chk("st2_aw_cnt", aw_cnt - aw0, 1);
        chk("st2_w_cnt", w_cnt - w0, 1);

        // Store, AW and W in the same cycle
        aw0 = aw_cnt; w0 = w_cnt;
        req_web = 4'b0111; req_addr = 32'h0000_0400;
        axi.AWREADY = 1; axi.WREADY = 1;
        cyc(); req_web = 4'hf; #1;
        chk("st3_both_valid", {axi.AWVALID, axi.WVALID}, 2'b11);
        chk("st3_wstrb", axi.WSTRB, 4'b1000);
        cyc(); axi.AWREADY = 0; axi.WREADY = 0; #1;
        chk("st3_bready", axi.BREADY, 1);
        axi.BVALID = 1;
        cyc(); axi.BVALID = 0; #1;
        chk("st3_aw_cnt", aw_cnt - aw0, 1);
        chk("st3_w_cnt", w_cnt - w0, 1);

        // Store with a simultaneous load request: write wins, AR never used
        ar0 = ar_hi;
        req_web = 4'b1110; req_read = 1; req_addr = 32'h0000_0500;
        axi.AWREADY = 1; axi.WREADY = 1;
        cyc(); req_web = 4'hf; req_read = 0; #1;
        chk("st4_arvalid", axi.ARVALID, 0);
        chk("st4_awvalid", axi.AWVALID, 1);
        chk("st4_wstrb", axi.WSTRB, 4'b0001);
        cyc(); axi.AWREADY = 0; axi.WREADY = 0; axi.BVALID = 1; #1;
        chk("st4_stall_bvalid", DM_STALL, 0);
        cyc(); axi.BVALID = 0; #1;
        chk("st4_ar_never", ar_hi - ar0, 0);

        // Slow ARREADY, request changes ignored, SLVERR on read
        req_read = 1; req_addr = 32'h3000_0004;
        cyc(); req_read = 0; req_addr = 32'hFFFF_FFF0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("slow_arvalid", axi.ARVALID, 1);
            chk("slow_araddr", axi.ARADDR, 32'h3000_0004);
            cyc();
        end
        axi.ARREADY = 1;
        cyc(); axi.ARREADY = 0; axi.RVALID = 1; axi.RDATA = 32'hCAFE_F00D; axi.RRESP = 2'b10; #1;
        chk("err_not_yet", resp_err, 0);
        cyc(); axi.RVALID = 0; axi.RRESP = 2'b00; #1;
        chk("err_pulse", resp_err, 1);
        chk("err_rdata", rdata, 32'hCAFE_F00D);
        cyc(); #1;
        chk("err_one_cycle", resp_err, 0);

        // Reset while waiting in RD_DATA
        req_read = 1; req_addr = 32'h0000_0700; axi.ARREADY = 1;
        cyc(); req_read = 0;
        cyc(); axi.ARREADY = 0; #1;
        chk("mid_rready", axi.RREADY, 1);
        rst = 1;
        cyc(); #1;
        chk("mid_rst_rready", axi.RREADY, 0);
        chk("mid_rst_arvalid", axi.ARVALID, 0);
        chk("mid_rst_stall", DM_STALL, 0);
        chk("mid_rst_rdata", rdata, 0);
        rst = 0;
        cyc(); #1;
        chk("mid_after_idle", {axi.ARVALID, axi.RREADY, DM_STALL}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, expected finish before 50000");
        $fatal(1, "timeout");
    end
endmodule
